// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction ROM
// and registers the fetched instruction and its PC into the IF/ID pipeline register.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          ROM_AW    = 10,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] rom_addr_o,
   output logic        rom_ce_o,
   input  logic [31:0] rom_instr_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        id_ready_i,
   output logic        if_id_valid_o,
   output logic [31:0] if_id_instr_o,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] pc_o,
   output logic        misalign_o
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic        rom_ce_s;
   logic        load_s;
   logic        jump_s;
   logic [31:0] pc_r;
   logic        if_id_valid_r;
   logic [31:0] if_id_instr_r;
   logic [31:0] if_id_pc_r;
   logic        misalign_r;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: IDLE is a single-cycle ROM-disable window after reset
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    next_state_s = FETCH;
         FETCH:   next_state_s = FETCH;
         default: next_state_s = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      rom_ce_s = 1'b0;
      case (state_r)
         IDLE:    rom_ce_s = 1'b0;
         FETCH:   rom_ce_s = 1'b1;
         default: rom_ce_s = 1'b0;
      endcase
   end

   // Redirect wins over a load; IF/ID may refill when empty or being drained
   assign jump_s = (state_r == FETCH) && jump_en_i;
   assign load_s = (state_r == FETCH) && (!if_id_valid_r || id_ready_i);

   // PC and IF/ID pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r          <= RESET_PC;
         if_id_valid_r <= 1'b0;
         if_id_instr_r <= NOP_INSTR;
         if_id_pc_r    <= 32'h0000_0000;
         misalign_r    <= 1'b0;
      end else if (jump_s) begin
         pc_r          <= {jump_addr_i[31:2], 2'b00};
         if_id_valid_r <= 1'b0;
         if_id_instr_r <= NOP_INSTR;
         misalign_r    <= |jump_addr_i[1:0];
      end else if (load_s) begin
         pc_r          <= pc_r + 32'd4;
         if_id_valid_r <= 1'b1;
         if_id_instr_r <= rom_instr_i;
         if_id_pc_r    <= pc_r;
         misalign_r    <= 1'b0;
      end else begin
         misalign_r    <= 1'b0;
      end
   end

   // Upper PC bits are dropped on purpose: the ROM aliases across the address space
   assign rom_addr_o    = {{(32 - ROM_AW){1'b0}}, pc_r[ROM_AW+1:2]};
   assign rom_ce_o      = rom_ce_s;
   assign pc_o          = pc_r;
   assign if_id_valid_o = if_id_valid_r;
   assign if_id_instr_o = if_id_instr_r;
   assign if_id_pc_o    = if_id_pc_r;
   assign misalign_o    = misalign_r;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V core. Owns the program counter, drives address and chip-enable into the combinational instruction ROM, and registers the returned instruction with its PC into the IF/ID pipeline register.
- Supports decode back-pressure (ready/valid), branch/jump redirect with flush, and a one-cycle post-reset ROM-disable window.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- ROM_AW, 10, ROM word-address width (1024 entries).
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush/reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rom_addr_o  out  32  word index to ROM = {zeros, pc[ROM_AW+1:2]}.
- rom_ce_o  out  1  ROM chip enable (1 = enable).
- rom_instr_i  in  32  instruction from ROM, combinational, same cycle as rom_addr_o.
- jump_en_i  in  1  redirect request from EX.
- jump_addr_i  in  32  redirect target (byte address).
- id_ready_i  in  1  decode can accept the IF/ID contents this cycle.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- if_id_instr_o  out  32  registered instruction.
- if_id_pc_o  out  32  byte PC of if_id_instr_o.
- pc_o  out  32  current fetch PC (byte address).
- misalign_o  out  1  one-cycle pulse: accepted jump target had addr[1:0] != 0.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=IDLE, if_id_valid_o=0, if_id_instr_o=NOP_INSTR, if_id_pc_o=0, misalign_o=0. rom_ce_o is 0 during IDLE, so ROM returns zero.
- FSM has 2 states:
  - IDLE: next edge goes to FETCH unconditionally (unless rst). Nothing is captured and pc does not advance.
  - FETCH: rom_ce_o=1 (combinational from state). Remains in FETCH until rst.
- Load condition: load = (state==FETCH) && (!if_id_valid_o || id_ready_i).
- Priority per edge, in FETCH: rst > jump_en_i > load > hold.
  - Jump: pc <= {jump_addr_i[31:2],2'b00}. IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc unchanged). misalign_o <= |jump_addr_i[1:0]. Jump applies even when decode is stalled.
  - Load: if_id_instr_o <= rom_instr_i, if_id_pc_o <= pc, if_id_valid_o <= 1, pc <= pc+4.
  - Hold (stall, no jump): pc and IF/ID unchanged; if_id_valid_o stays 1.
  - misalign_o <= 0 on every edge without an accepted jump.
- jump_en_i in IDLE is ignored. The fetch from RESET_PC always follows reset.
- Latency: the instruction at pc appears on if_id_* one edge after the address is presented. First valid IF/ID appears at the 2nd edge after rst is released.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). rom_addr_o uses pc[ROM_AW+1:2] only; upper pc bits are ignored (ROM aliasing is intentional).
- The ROM is never read with rom_ce_o=0 while a load occurs, so the zero output is never captured as valid.
- Reset asserted mid-stall or mid-jump: reset wins and all state returns to reset values on that edge.

Test Plan:
- Reset release, id_ready_i=1, ROM[0..2]=0x00100093,0x00200113,0x00308193 -> edge1 rom_ce_o rises. Edges 2,3,4 give if_id_valid_o=1 with (pc,instr)=(0,0x00100093),(4,0x00200113),(8,0x00308193).
- Stall: id_ready_i=0 for 3 cycles after IF/ID holds pc=4 -> if_id_* frozen at (4,0x00200113) and pc_o frozen at 8. Release -> next edge gives (8,ROM[2]).
- Jump with jump_addr_i=0x40 while id_ready_i=0 -> next edge: if_id_valid_o=0, if_id_instr_o=0x00000013, pc_o=0x40, misalign_o=0. Following edge: (0x40,ROM[16]) valid.
- Misaligned jump to 0x0000_0046 -> pc_o=0x44, misalign_o=1 for exactly one cycle.
- RESET_PC=32'hFFFF_FFFC, continuous ready -> captured PCs are FFFF_FFFC then 0. rom_addr_o goes 0x3FF then 0x000.
- rst pulsed for 1 cycle during a stall with valid=1 -> if_id_valid_o=0, pc_o=RESET_PC, rom_ce_o=0 for one cycle, then normal fetch resumes.
